// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: shared ROM geometry, master count, owner index type and FSM states
package bus_arbiter_pkg;

    localparam int ROM_ADDR_W = 11;
    localparam int ROM_DATA_W = 32;

    localparam int N_MASTERS = 4;
    localparam int OWNER_W   = 2;

    typedef logic [OWNER_W-1:0] owner_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    function automatic logic [N_MASTERS-1:0] onehot_low(input owner_t idx);
        return ~(N_MASTERS'(1) << idx);
    endfunction

endpackage

// File: rtl/bus_arb_prio.sv
// bus_arb_prio: first active request found scanning upward from start, wrapping at the top
module bus_arb_prio
    import bus_arbiter_pkg::*;
(
    input  logic [N_MASTERS-1:0] req,
    input  owner_t               start,
    output owner_t               winner,
    output logic                 valid
);

    logic [2*N_MASTERS-1:0] dbl;
    logic [N_MASTERS-1:0]   rot;
    owner_t                 off;

    // rotate so start sits at bit 0, take the lowest set bit, rotate the index back
    always_comb begin
        dbl = {req, req};
        rot = dbl[{1'b0, start} +: N_MASTERS];
        off = '0;
        for (int i = N_MASTERS - 1; i >= 0; i--)
            if (rot[i]) off = owner_t'(i);
        winner = start + off;
        valid  = |req;
    end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: four-master ROM bus arbiter; BUS_ARB_ROUND_ROBIN_EN selects round-robin over fixed priority
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = ROM_ADDR_W,
    parameter int DATA_W = ROM_DATA_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_MASTERS-1:0]          m_req_,
    input  logic [N_MASTERS-1:0]          m_as_,
    input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
    output logic [N_MASTERS-1:0]          m_grnt_,
    output logic [N_MASTERS-1:0]          m_rdy_,
    output logic [DATA_W-1:0]             m_rd_data,
    output logic                          rom_cs_,
    output logic                          rom_as_,
    output logic [ADDR_W-1:0]             rom_addr,
    input  logic [DATA_W-1:0]             rom_rd_data,
    input  logic                          rom_rdy_
);

    arb_state_e           state, state_nxt;
    owner_t               owner, owner_nxt, rdy_sel, start, winner;
    logic                 win_vld, take;
    logic [N_MASTERS-1:0] req;

    assign req = ~m_req_;

    bus_arb_prio u_prio (
        .req    (req),
        .start  (start),
        .winner (winner),
        .valid  (win_vld)
    );

    // a new winner is taken from idle, or when the current owner has let go
    assign take = win_vld && (state == ST_IDLE || !req[owner]);

`ifdef BUS_ARB_ROUND_ROBIN_EN
    owner_t rr_ptr;

    // remember the most recent grant so the search begins just past it
    always_ff @(posedge clk or negedge reset)
        if (!reset) rr_ptr <= owner_t'(N_MASTERS - 1);
        else if (take) rr_ptr <= winner;

    assign start = rr_ptr + 1'b1;
`else
    assign start = '0;
`endif

    // state, owner and ready-routing registers
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state   <= ST_IDLE;
            owner   <= '0;
            rdy_sel <= '0;
        end else begin
            state   <= state_nxt;
            owner   <= owner_nxt;
            rdy_sel <= rom_as_ ? rdy_sel : owner;
        end

    // next state: hand over without a gap when someone else is waiting
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        if (take) begin
            state_nxt = ST_GRANT;
            owner_nxt = winner;
        end else if (state == ST_GRANT && !req[owner]) begin
            state_nxt = ST_IDLE;
        end
    end

    // bus outputs driven from registered owner; strobe only while the owner still requests
    always_comb begin
        m_grnt_  = '1;
        rom_cs_  = 1'b1;
        rom_as_  = 1'b1;
        rom_addr = '0;
        if (state == ST_GRANT) begin
            m_grnt_  = onehot_low(owner);
            rom_cs_  = 1'b0;
            rom_as_  = m_req_[owner] | m_as_[owner];
            rom_addr = m_addr[owner*ADDR_W +: ADDR_W];
        end
    end

    assign m_rdy_    = (!reset || rom_rdy_) ? '1 : onehot_low(rdy_sel);
    assign m_rd_data = rom_rd_data;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: randomized and directed checks against a behavioural arbitration model
module tb_bus_arbiter;

    localparam int AW = 11;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    m_req_, m_as_;
    logic [4*AW-1:0] m_addr;
    logic [3:0]    m_grnt_, m_rdy_;
    logic [DW-1:0] m_rd_data, rom_rd_data;
    logic          rom_cs_, rom_as_, rom_rdy_;
    logic [AW-1:0] rom_addr;

    int checks = 0;
    int failures = 0;

    bit g;
    int own, last, sel;

    always #5 clk = ~clk;

    bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .m_req_      (m_req_),
        .m_as_       (m_as_),
        .m_addr      (m_addr),
        .m_grnt_     (m_grnt_),
        .m_rdy_      (m_rdy_),
        .m_rd_data   (m_rd_data),
        .rom_cs_     (rom_cs_),
        .rom_as_     (rom_as_),
        .rom_addr    (rom_addr),
        .rom_rd_data (rom_rd_data),
        .rom_rdy_    (rom_rdy_)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int st);
        for (int k = 0; k < 4; k++)
            if (r[(st + k) % 4]) return (st + k) % 4;
        return -1;
    endfunction

    function automatic int idx_of(input logic [3:0] gv);
        for (int i = 0; i < 4; i++)
            if (!gv[i]) return i;
        return -1;
    endfunction

    function automatic logic [4*AW-1:0] addr_at(input int m, input logic [AW-1:0] a);
        logic [4*AW-1:0] v;
        v = '0;
        v[m*AW +: AW] = a;
        return v;
    endfunction

    task automatic model_reset();
        g = 0; own = 0; last = 3; sel = 0;
    endtask

    task automatic check_outs(input string tag);
        logic [3:0] one, eg, er;
        logic ecs, eas;
        logic [AW-1:0] ea;
        one = 4'b0001;
        eg = 4'hF; er = 4'hF; ecs = 1'b1; eas = 1'b1; ea = '0;
        if (reset) begin
            if (g) begin
                eg  = ~(one << own);
                ecs = 1'b0;
                eas = (m_req_[own] == 1'b0 && m_as_[own] == 1'b0) ? 1'b0 : 1'b1;
                ea  = m_addr[own*AW +: AW];
            end
            if (!rom_rdy_) er = ~(one << sel);
        end
        chk({tag, ".grnt"}, 64'(m_grnt_), 64'(eg));
        chk({tag, ".rdy"}, 64'(m_rdy_), 64'(er));
        chk({tag, ".cs"}, 64'(rom_cs_), 64'(ecs));
        chk({tag, ".as"}, 64'(rom_as_), 64'(eas));
        chk({tag, ".addr"}, 64'(rom_addr), 64'(ea));
        chk({tag, ".data"}, 64'(m_rd_data), 64'(rom_rd_data));
    endtask

    task automatic model_step();
        logic [3:0] r;
        int st, w;
        r = ~m_req_;
`ifdef BUS_ARB_ROUND_ROBIN_EN
        st = (last + 1) % 4;
`else
        st = 0;
`endif
        if (g && r[own] && !m_as_[own]) sel = own;
        if (!g || !r[own]) begin
            w = pick(r, st);
            if (w >= 0) begin
                g = 1; own = w; last = w;
            end else begin
                g = 0;
            end
        end
    endtask

    task automatic drive(input string tag, input logic [3:0] rq, input logic [3:0] asv,
                         input logic [4*AW-1:0] ad, input logic rr, input logic [DW-1:0] rd);
        @(negedge clk);
        m_req_ = rq; m_as_ = asv; m_addr = ad; rom_rdy_ = rr; rom_rd_data = rd;
        #1 check_outs(tag);
        model_step();
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clk);
        #1 check_outs({tag, ".pre"});
        #1 reset = 1'b0;
        rom_rdy_ = 1'b0;
        model_reset();
        #1 check_outs({tag, ".async"});
        @(negedge clk);
        #1 check_outs({tag, ".held"});
        @(negedge clk);
        reset = 1'b1; m_req_ = 4'hF; m_as_ = 4'hF; rom_rdy_ = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int order[$];
        int h, prev, cur;
        logic [3:0] rq, asv;
        reset = 1'b0; m_req_ = 4'hF; m_as_ = 4'hF; m_addr = '0;
        rom_rdy_ = 1'b0; rom_rd_data = 32'hDEAD_BEEF;
        model_reset();
        @(negedge clk);
        #1 check_outs("por");
        @(negedge clk);
        reset = 1'b1; rom_rdy_ = 1'b1;

        // single master 2 read at 0x010
        drive("m2.req", 4'b1011, 4'b1011, addr_at(2, 11'h010), 1'b1, 32'h1);
        drive("m2.gnt", 4'b1011, 4'b1011, addr_at(2, 11'h010), 1'b1, 32'h2);
        chk("m2.gnt_exact", 64'(m_grnt_), 64'(4'b1011));
        chk("m2.addr_exact", 64'(rom_addr), 64'(11'h010));
        drive("m2.rdy", 4'b1011, 4'b1111, addr_at(2, 11'h010), 1'b0, 32'h3);
        chk("m2.rdy_exact", 64'(m_rdy_), 64'(4'b1011));
        drive("m2.rel", 4'b1111, 4'b1111, '0, 1'b1, 32'h4);
        drive("m2.idle", 4'b1111, 4'b1111, '0, 1'b1, 32'h5);
        chk("m2.idle_exact", 64'(m_grnt_), 64'(4'hF));

`ifndef BUS_ARB_ROUND_ROBIN_EN
        // masters 0 and 3 together: 0 first, then 3 with no gap
        drive("fp.a", 4'b0110, 4'hF, '0, 1'b1, 32'h10);
        drive("fp.b", 4'b0110, 4'hF, '0, 1'b1, 32'h11);
        chk("fp.m0", 64'(m_grnt_), 64'(4'b1110));
        drive("fp.c", 4'b0111, 4'hF, '0, 1'b1, 32'h12);
        chk("fp.m0_hold", 64'(m_grnt_), 64'(4'b1110));
        drive("fp.d", 4'b0111, 4'hF, '0, 1'b1, 32'h13);
        chk("fp.m3", 64'(m_grnt_), 64'(4'b0111));
        drive("fp.e", 4'hF, 4'hF, '0, 1'b1, 32'h14);
        drive("fp.f", 4'hF, 4'hF, '0, 1'b1, 32'h15);
`else
        // all four request continuously, each owner drops after two granted cycles
        apply_reset("rr.rst");
        h = 0; prev = -1;
        for (int c = 0; c < 24; c++) begin
            rq = 4'b0000;
            if (g) begin
                if (own == prev) h++;
                else begin h = 1; prev = own; end
                if (h >= 3) rq[own] = 1'b1;
            end
            drive("rr", rq, 4'hF, '0, 1'b1, $urandom);
            cur = idx_of(m_grnt_);
            if (cur >= 0 && (order.size() == 0 || order[$] != cur)) order.push_back(cur);
        end
        chk("rr.count", 64'(order.size() >= 5), 64'(1));
        for (int i = 0; i < 5; i++)
            chk("rr.order", 64'(i < order.size() ? order[i] : -1), 64'(i % 4));
        drive("rr.rel", 4'hF, 4'hF, '0, 1'b1, 32'h0);
        drive("rr.idle", 4'hF, 4'hF, '0, 1'b1, 32'h0);
`endif

        // master 1 reads 0x7FF then releases with master 2 waiting
        apply_reset("hand.rst");
        drive("hand.a", 4'b1101, 4'hF, '0, 1'b1, 32'h20);
        drive("hand.b", 4'b1001, 4'hF, '0, 1'b1, 32'h21);
        chk("hand.m1", 64'(m_grnt_), 64'(4'b1101));
        drive("hand.as", 4'b1001, 4'b1101, addr_at(1, 11'h7FF), 1'b1, 32'h22);
        chk("hand.as_exact", 64'(rom_as_), 64'(1'b0));
        chk("hand.addr_exact", 64'(rom_addr), 64'(11'h7FF));
        drive("hand.rel", 4'b1011, 4'hF, '0, 1'b0, 32'h23);
        chk("hand.rdy1", 64'(m_rdy_), 64'(4'b1101));
        drive("hand.m2", 4'b1011, 4'hF, '0, 1'b0, 32'h24);
        chk("hand.m2_gnt", 64'(m_grnt_), 64'(4'b1011));
        chk("hand.rdy_routed", 64'(m_rdy_), 64'(4'b1101));
        drive("hand.end", 4'hF, 4'hF, '0, 1'b1, 32'h25);

        // reset while master 0 owns the bus, then master 3 arbitrates immediately
        drive("mid.a", 4'b1110, 4'b1110, addr_at(0, 11'h155), 1'b1, 32'h30);
        drive("mid.b", 4'b1110, 4'b1110, addr_at(0, 11'h155), 1'b1, 32'h31);
        chk("mid.owned", 64'(m_grnt_), 64'(4'b1110));
        apply_reset("mid.rst");
        drive("mid.req3", 4'b0111, 4'hF, '0, 1'b1, 32'h32);
        chk("mid.idle", 64'(m_grnt_), 64'(4'hF));
        drive("mid.gnt3", 4'b0111, 4'hF, '0, 1'b1, 32'h33);
        chk("mid.m3", 64'(m_grnt_), 64'(4'b0111));
        drive("mid.end", 4'hF, 4'hF, '0, 1'b1, 32'h34);

        // random traffic with sticky requests and occasional resets
        rq = 4'hF;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 9) < 3) rq[i] = ~rq[i];
            asv = 4'($urandom);
            if ($urandom_range(0, 149) == 0) begin
                apply_reset("rnd.rst");
                rq = 4'hF;
            end
            drive("rnd", rq, asv, {$urandom, $urandom}, 1'($urandom), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, ROM word address width.
REQ-002 SHALL have parameter DATA_W, default 32, ROM read data width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port m_req_  input  4  per-master bus request, active-low; bit i is master i.
REQ-006 SHALL have port m_as_  input  4  per-master address strobe, active-low.
REQ-007 SHALL have port m_addr  input  4*ADDR_W  packed master addresses; master i is bits [i*ADDR_W +: ADDR_W].
REQ-008 SHALL have port m_grnt_  output  4  one-hot-low grant; at most one bit low.
REQ-009 SHALL have port m_rdy_  output  4  per-master ready, active-low.
REQ-010 SHALL have port m_rd_data  output  DATA_W  read data, broadcast to all masters.
REQ-011 SHALL have port rom_cs_  output  1  ROM chip select, active-low.
REQ-012 SHALL have port rom_as_  output  1  ROM address strobe, active-low.
REQ-013 SHALL have port rom_addr  output  ADDR_W  ROM address.
REQ-014 SHALL have port rom_rd_data  input  DATA_W  ROM read data.
REQ-015 SHALL have port rom_rdy_  input  1  ROM ready, low one cycle after a cycle with rom_cs_ and rom_as_ both low.

Function
REQ-016 SHALL implement a two-state FSM: IDLE and GRANT, with a registered 2-bit owner index.
REQ-017 IDLE -> GRANT on the first edge where any m_req_ bit is sampled low. The winner's m_grnt_ goes low after that edge, so grant latency is 1 cycle.
REQ-018 In GRANT, the owner keeps the grant while its m_req_ stays low. Requests from other masters do not preempt it.
REQ-019 At the edge where the owner's m_req_ is sampled high:
- if another request is low, the grant moves directly to the next winner at that edge (no idle cycle);
- otherwise the FSM returns to IDLE and all m_grnt_ go high.
REQ-020 rom_cs_ SHALL be low exactly while the FSM is in GRANT.
REQ-021 rom_as_ = owner's m_as_ when in GRANT and the owner's m_req_ is low; otherwise high. This path is combinational from registered state.
REQ-022 rom_addr = owner's m_addr slice in GRANT; otherwise all zeros.
REQ-023 A registered rdy_sel captures the owner index on every edge where rom_as_ is low.
REQ-024 m_rdy_[rdy_sel] = rom_rdy_, and all other m_rdy_ bits are high. This lets the last read's ready reach its issuer even after a handover.
REQ-025 m_rd_data = rom_rd_data, combinational passthrough.
REQ-026 If the owner releases and re-requests in a later cycle, it re-arbitrates like any other master.

Reset
REQ-027 Reset low SHALL immediately set the following, independent of clk, even mid-access:
- FSM = IDLE;
- m_grnt_ = 4'b1111, m_rdy_ = 4'b1111;
- rom_cs_ = 1, rom_as_ = 1, rom_addr = 0;
- owner = 0, rdy_sel = 0, round-robin pointer = 3.
REQ-028 After reset deasserts, the first arbitration SHALL follow REQ-017 with no extra wait cycles.

Configuration
REQ-029 Macro BUS_ARB_ROUND_ROBIN_EN:
- defined: round-robin arbitration. The search starts at (last granted index + 1) mod 4, and the pointer updates on every grant.
- undefined: fixed priority, lowest index wins, and no pointer register is built.

Structure
REQ-030 The following SHALL live in the shared header/package alongside the existing ROM definitions:
- FSM state encodings;
- owner index width;
- master count (4).
Active-low enable/disable and reset-edge definitions SHALL come from the existing global header.
REQ-031 The winner search SHALL be a sub-module, bus_arb_prio (4-bit request, 2-bit start index -> 2-bit winner + valid), reused for both arbitration modes.

Verification
REQ-032 Reset, then master 2 requests alone with as_ low and addr 0x010 -> next cycle m_grnt_ = 4'b1011, rom_cs_ = 0, rom_addr = 0x010; one cycle later m_rdy_ = 4'b1011.
REQ-033 Masters 0 and 3 request in the same cycle, fixed priority (macro undefined) -> master 0 granted; master 3 granted at the edge master 0 releases, with no gap.
REQ-034 Macro defined, all four requesting continuously, each releasing after 2 cycles -> grant order 0, 1, 2, 3, 0.
REQ-035 Master 1 issues as_ at addr 0x7FF and releases in the same cycle, master 2 pending -> m_rdy_[1] low the next cycle while m_grnt_[2] is low; m_rdy_[2] stays high.
REQ-036 Reset asserted mid-GRANT -> all outputs at REQ-027 values within the same cycle; after release, a request from master 3 is granted 1 cycle later.
